// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline sequencing, hazard detection and forwarding control
//
// Purpose:
//    Drives the enable/flush controls of the PC, IF/ID, ID/EXE and EXE/MEM
//    registers of the 5-stage core. It handles load-use bubbles, branch/jump
//    redirects and data-memory wait states. It also produces the EXE operand
//    forwarding selects and a sticky memory-timeout fault.
//
// Optional feature macro: HAZ_PERF_CNT_EN (load-use / redirect counters).
//
// Ports:
//    clk, clr                 clock (rising edge), async active-high reset
//    id_rs, id_rt, id_uses_rt source registers of the instruction in ID
//    ex_*                     EXE-stage fields (sources, dest, load, redirect)
//    mem_regwrite, mem_wreg   MEM-stage writeback info for forwarding
//    wb_regwrite, wb_wreg     WB-stage writeback info for forwarding
//    mem_busy                 data memory not ready this cycle
//    pc_en .. exmem_en        pipeline register enables / flushes
//    fwd_a, fwd_b             00 regfile, 01 WB, 10 MEM
//    state, fault             FSM state (0 RUN, 1 MEMW, 2 FAULT), sticky fault
//    stall_cnt, flush_cnt     performance counters (0 when feature disabled)

module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic [4:0]       ex_rs,
   input  logic [4:0]       ex_rt,
   input  logic             ex_regwrite,
   input  logic             ex_memtoreg,
   input  logic [4:0]       ex_wreg,
   input  logic             ex_branch_taken,
   input  logic             ex_jump,
   input  logic             mem_regwrite,
   input  logic [4:0]       mem_wreg,
   input  logic             wb_regwrite,
   input  logic [4:0]       wb_wreg,
   input  logic             mem_busy,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [1:0]       state,
   output logic             fault,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      MEMW  = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam int WC_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WC_W:0]   TIMEOUT_V = (WC_W + 1)'(MEM_TIMEOUT);
   localparam logic [WC_W-1:0] WC_ONE    = WC_W'(1);

   state_t          state_q, state_d;
   logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
   logic            fault_q, fault_d;
   logic [WC_W:0]   wait_inc;

   logic load_use;
   logic redirect;
   logic frozen;
   logic bubble_issue;
   logic redirect_issue;

   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic       m_we,
                                          input logic [4:0] m_reg,
                                          input logic       w_we,
                                          input logic [4:0] w_reg);
      if (m_we && (m_reg != 5'd0) && (m_reg == src))
         return 2'b10;
      else if (w_we && (w_reg != 5'd0) && (w_reg == src))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   always_comb begin
      load_use = ex_memtoreg & ex_regwrite & (ex_wreg != 5'd0) &
                 ((ex_wreg == id_rs) | (id_uses_rt & (ex_wreg == id_rt)));
      redirect = ex_branch_taken | ex_jump;
      frozen   = (state_q == FAULT) | mem_busy;

      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;

      // Pending redirect/load-use inputs stay stable across a freeze, so they
      // are naturally acted on in the first cycle after mem_busy drops.
      if (frozen) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
      end else if (redirect) begin
         // ID instruction is squashed, so any load-use on it is irrelevant.
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (load_use) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end

      bubble_issue   = ~frozen & ~redirect & load_use;
      redirect_issue = ~frozen & redirect;

      fwd_a = fwd_sel(ex_rs, mem_regwrite, mem_wreg, wb_regwrite, wb_wreg);
      fwd_b = fwd_sel(ex_rt, mem_regwrite, mem_wreg, wb_regwrite, wb_wreg);
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      fault_d    = fault_q;
      wait_inc   = {1'b0, wait_cnt_q} + (WC_W + 1)'(1);
      case (state_q)
         RUN: begin
            if (mem_busy) begin
               state_d    = MEMW;
               wait_cnt_d = WC_ONE;
            end
         end
         MEMW: begin
            if (mem_busy) begin
               if (wait_cnt_q != {WC_W{1'b1}})
                  wait_cnt_d = wait_cnt_q + WC_ONE;
               // The count including this cycle reaching the limit means
               // MEM_TIMEOUT consecutive busy cycles have elapsed.
               if ((MEM_TIMEOUT != 0) && (wait_inc >= TIMEOUT_V)) begin
                  state_d = FAULT;
                  fault_d = 1'b1;
               end
            end else begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         fault_q    <= fault_d;
      end
   end

   assign state = state_q;
   assign fault = fault_q;

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q + (bubble_issue ? CNT_W'(1) : CNT_W'(0));
      flush_cnt_d = flush_cnt_q + (redirect_issue ? CNT_W'(1) : CNT_W'(0));
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   logic perf_unused;
   assign perf_unused = bubble_issue ^ redirect_issue;
   assign stall_cnt   = '0;
   assign flush_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl

module tb_hazard_ctrl;

   localparam int CNT_W = 32;
`ifdef HAZ_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic             clk;
   logic             clr;
   logic [4:0]       id_rs, id_rt;
   logic             id_uses_rt;
   logic [4:0]       ex_rs, ex_rt;
   logic             ex_regwrite, ex_memtoreg;
   logic [4:0]       ex_wreg;
   logic             ex_branch_taken, ex_jump;
   logic             mem_regwrite;
   logic [4:0]       mem_wreg;
   logic             wb_regwrite;
   logic [4:0]       wb_wreg;
   logic             mem_busy;
   logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
   logic [1:0]       fwd_a, fwd_b, state;
   logic             fault;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int checks;
   int errors;

   hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .clr(clr),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_wreg(ex_wreg),
      .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
      .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg),
      .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg),
      .mem_busy(mem_busy),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state), .fault(fault),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] cnt_exp(input int n);
      return PERF ? 32'(n) : 32'd0;
   endfunction

   // Advance one clock; inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_rs = 0; id_rt = 0; id_uses_rt = 0;
      ex_rs = 0; ex_rt = 0; ex_regwrite = 0; ex_memtoreg = 0; ex_wreg = 0;
      ex_branch_taken = 0; ex_jump = 0;
      mem_regwrite = 0; mem_wreg = 0; wb_regwrite = 0; wb_wreg = 0;
      mem_busy = 0;
   endtask

   // Packs {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush}.
   function automatic logic [31:0] ctl();
      return {26'd0, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush};
   endfunction

   initial begin
      checks = 0;
      errors = 0;
      idle_inputs();
      clr = 1'b1;
      #2;
      check("reset_state", state, 0);
      check("reset_fault", fault, 0);
      check("reset_ctl", ctl(), 32'b111100);
      check("reset_stall_cnt", stall_cnt, 0);
      check("reset_flush_cnt", flush_cnt, 0);
      tick();
      tick();
      clr = 1'b0;
      tick();

      // lw $2 in EXE, add $3,$2,$4 in ID
      ex_memtoreg = 1; ex_regwrite = 1; ex_wreg = 2; id_rs = 2; id_rt = 4; id_uses_rt = 1;
      #1;
      check("lu_ctl", ctl(), 32'b001101);
      tick();
      idle_inputs();
      mem_regwrite = 1; mem_wreg = 2; ex_rs = 2; ex_rt = 4;
      #1;
      check("lu_next_fwd_a", fwd_a, 2'b10);
      check("lu_next_fwd_b", fwd_b, 2'b00);
      check("lu_next_ctl", ctl(), 32'b111100);
      check("lu_stall_cnt", stall_cnt, cnt_exp(1));
      tick();

      // load-use on rt only
      idle_inputs();
      ex_memtoreg = 1; ex_regwrite = 1; ex_wreg = 7; id_rs = 1; id_rt = 7; id_uses_rt = 1;
      #1;
      check("lu_rt_ctl", ctl(), 32'b001101);
      id_uses_rt = 0;
      #1;
      check("lu_rt_unused_ctl", ctl(), 32'b111100);
      idle_inputs();
      tick();

      // branch taken with a load-use match: redirect wins
      ex_branch_taken = 1; ex_memtoreg = 1; ex_regwrite = 1; ex_wreg = 3; id_rs = 3;
      #1;
      check("br_lu_ctl", ctl(), 32'b111111);
      tick();
      idle_inputs();
      #1;
      check("br_stall_cnt", stall_cnt, cnt_exp(1));
      check("br_flush_cnt", flush_cnt, cnt_exp(1));

      // mem_busy for 3 cycles with a pending jump
      ex_jump = 1; mem_busy = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("busy_ctl_%0d", i), ctl(), 32'b000000);
         check($sformatf("busy_state_%0d", i), state, (i == 0) ? 0 : 1);
         tick();
      end
      mem_busy = 0;
      #1;
      check("busy_drop_state", state, 1);
      check("busy_drop_ctl", ctl(), 32'b111111);
      tick();
      ex_jump = 0;
      #1;
      check("busy_back_run", state, 0);
      check("busy_flush_cnt", flush_cnt, cnt_exp(2));
      check("busy_fault", fault, 0);

      // forwarding priority
      mem_regwrite = 1; mem_wreg = 5; wb_regwrite = 1; wb_wreg = 5; ex_rs = 5; ex_rt = 0;
      #1;
      check("fwd_mem_a", fwd_a, 2'b10);
      check("fwd_r0_b", fwd_b, 2'b00);
      mem_regwrite = 0;
      #1;
      check("fwd_wb_a", fwd_a, 2'b01);
      ex_rt = 5; ex_rs = 6;
      #1;
      check("fwd_wb_b", fwd_b, 2'b01);
      check("fwd_none_a", fwd_a, 2'b00);
      mem_regwrite = 1; mem_wreg = 0; wb_regwrite = 0; wb_wreg = 0; ex_rs = 0;
      #1;
      check("fwd_reg0_a", fwd_a, 2'b00);
      idle_inputs();

      // load targeting $0 never stalls
      ex_memtoreg = 1; ex_regwrite = 1; ex_wreg = 0; id_rs = 0;
      #1;
      check("lu_r0_ctl", ctl(), 32'b111100);
      idle_inputs();
      tick();

      // memory timeout with MEM_TIMEOUT=4
      mem_busy = 1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check($sformatf("to_state_%0d", i), state, 1);
         check($sformatf("to_fault_%0d", i), fault, 0);
      end
      tick();
      check("to_state_fault", state, 2);
      check("to_fault_set", fault, 1);
      mem_busy = 0; ex_jump = 1;
      mem_regwrite = 1; mem_wreg = 9; ex_rs = 9;
      #1;
      check("fault_ctl", ctl(), 32'b000000);
      check("fault_fwd_a", fwd_a, 2'b10);
      tick();
      check("fault_sticky", state, 2);
      check("fault_flush_cnt", flush_cnt, cnt_exp(2));
      clr = 1;
      #1;
      check("clr_state", state, 0);
      check("clr_fault", fault, 0);
      check("clr_ctl", ctl(), 32'b111111);
      check("clr_flush_cnt", flush_cnt, 0);
      tick();
      clr = 0;
      idle_inputs();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
